// File: rtl/polinomio_horner_pkg.sv
// Shared constants for the Horner polynomial evaluator: FSM state encodings,
// ALU opcodes and the coefficient address width helper.
package polinomio_horner_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_MUL  = 3'd2,
      ST_ADD  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

   // Address width for DEGREE+1 coefficients, never narrower than one bit.
   function automatic int calc_aw(input int degree);
      if (degree + 1 <= 1) return 1;
      return $clog2(degree + 1);
   endfunction

endpackage

// File: rtl/polinomio_horner_if.sv
// Coefficient-write, start and result bundle of the Horner evaluator.
// AW must equal polinomio_horner_pkg::calc_aw(DEGREE) of the attached core.
interface polinomio_horner_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 2
) ();
   logic             coef_we;
   logic [AW-1:0]    coef_addr;
   logic [WIDTH-1:0] coef_data;
   logic             start;
   logic [WIDTH-1:0] x;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] resultado;
   logic             ovf;

   modport master (
      output coef_we, coef_addr, coef_data, start, x,
      input  busy, done, resultado, ovf
   );

   modport slave (
      input  coef_we, coef_addr, coef_data, start, x,
      output busy, done, resultado, ovf
   );
endinterface

// File: rtl/polinomio_horner_ula.sv
// ula_param: WIDTH-bit unsigned add/multiply unit; carry flags a result that
// does not fit in WIDTH bits (sum carry-out or non-zero product high half).
module ula_param
   import polinomio_horner_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic [WIDTH-1:0] result,
   output logic             carry
);
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     sum;

   always_comb begin
      prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      sum    = {1'b0, a} + {1'b0, b};
      result = sum[WIDTH-1:0];
      carry  = sum[WIDTH];
      if (op == OP_MUL) begin
         result = prod[WIDTH-1:0];
         carry  = |prod[2*WIDTH-1:WIDTH];
      end
   end
endmodule

// File: rtl/polinomio_horner.sv
// Horner-rule evaluator of p(x) = sum coef[i]*x^i modulo 2^WIDTH.
// Define POLINOMIO_HORNER_OVF_EN to build the sticky overflow flag.
module polinomio_horner
   import polinomio_horner_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DEGREE = 2
) (
   input  logic              clk,
   input  logic              rst,
   polinomio_horner_if.slave bus
);
   localparam int AW = calc_aw(DEGREE);
   localparam logic [AW-1:0] I_TOP = AW'((DEGREE > 0) ? DEGREE - 1 : 0);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] coef_reg [DEGREE+1];
   logic [DEGREE:0]  coef_sel;
   logic [WIDTH-1:0] acc_reg, x_reg, resultado_reg;
   logic [AW-1:0]    i_reg;
   logic [WIDTH-1:0] coef_rd;
   logic             alu_op;
   logic [WIDTH-1:0] alu_b, alu_y;
   logic             alu_carry;
   logic             coef_wr_ok;

   // Writes land only in IDLE; out-of-range addresses select no entry.
   assign coef_wr_ok = bus.coef_we && (state_reg == ST_IDLE);

   generate
      for (genvar gi = 0; gi <= DEGREE; gi++) begin : g_sel
         assign coef_sel[gi] = coef_wr_ok && (bus.coef_addr == AW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int k = 0; k <= DEGREE; k++) begin
         if (rst) begin
            coef_reg[k] <= '0;
         end else if (coef_sel[k]) begin
            coef_reg[k] <= bus.coef_data;
         end
      end
   end

   assign coef_rd = coef_reg[i_reg];

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      alu_op     = OP_ADD;
      alu_b      = coef_rd;
      case (state_reg)
         ST_IDLE: if (bus.start) state_next = ST_LOAD;
         ST_LOAD: state_next = (DEGREE == 0) ? ST_DONE : ST_MUL;
         ST_MUL: begin
            alu_op     = OP_MUL;
            alu_b      = x_reg;
            state_next = ST_ADD;
         end
         ST_ADD:  state_next = (i_reg == '0) ? ST_DONE : ST_MUL;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   ula_param #(.WIDTH(WIDTH)) u_ula (
      .a      (acc_reg),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_y),
      .carry  (alu_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg       <= '0;
         x_reg         <= '0;
         i_reg         <= '0;
         resultado_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: if (bus.start) x_reg <= bus.x;
            ST_LOAD: begin
               acc_reg <= coef_reg[DEGREE];
               i_reg   <= I_TOP;
               if (DEGREE == 0) resultado_reg <= coef_reg[0];
            end
            ST_MUL: acc_reg <= alu_y;
            ST_ADD: begin
               acc_reg <= alu_y;
               if (i_reg == '0) resultado_reg <= alu_y;
               else             i_reg         <= i_reg - 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef POLINOMIO_HORNER_OVF_EN
   logic ovf_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else if (state_reg == ST_IDLE && bus.start) begin
         ovf_reg <= 1'b0;
      end else if ((state_reg == ST_MUL || state_reg == ST_ADD) && alu_carry) begin
         ovf_reg <= 1'b1;
      end
   end

   assign bus.ovf = ovf_reg;
`else
   logic unused_alu_carry;
   assign unused_alu_carry = alu_carry;
   assign bus.ovf          = 1'b0;
`endif

   assign bus.busy      = (state_reg != ST_IDLE);
   assign bus.done      = (state_reg == ST_DONE);
   assign bus.resultado = resultado_reg;
endmodule

// File: tb/tb_polinomio_horner.sv
// Directed bench for polinomio_horner: a DEGREE=2 instance driven from a vector
// table plus hand sequences, and a DEGREE=0 instance for the minimal latency.
module tb_polinomio_horner;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

`ifdef POLINOMIO_HORNER_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   polinomio_horner_if #(.WIDTH(16), .AW(2)) bus2 ();
   polinomio_horner_if #(.WIDTH(16), .AW(1)) bus0 ();

   polinomio_horner #(.WIDTH(16), .DEGREE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
   polinomio_horner #(.WIDTH(16), .DEGREE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

   typedef struct {
      logic [15:0] c0, c1, c2, xv, res;
      logic        ovf;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr2(input logic [1:0] a, input logic [15:0] d);
      bus2.coef_we = 1'b1; bus2.coef_addr = a; bus2.coef_data = d;
      tick();
      bus2.coef_we = 1'b0;
   endtask

   task automatic load3(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
      wr2(2'd0, c0); wr2(2'd1, c1); wr2(2'd2, c2);
   endtask

   // Returns edges counted from the one that samples start up to done.
   task automatic eval2(input logic [15:0] xv, output int lat);
      bus2.start = 1'b1; bus2.x = xv;
      tick();
      bus2.start = 1'b0;
      lat = 1;
      while (!bus2.done && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat, ndone;
      vecs[0] = '{16'd3,     16'd2,  16'd1,  16'd5,      16'd38,    1'b0};
      vecs[1] = '{16'd0,     16'd0,  16'd2,  16'hFFFF,   16'h0002,  1'b1};
      vecs[2] = '{16'd0,     16'd0,  16'd0,  16'h1234,   16'd0,     1'b0};
      vecs[3] = '{16'd1,     16'd1,  16'd1,  16'd0,      16'd1,     1'b0};
      vecs[4] = '{16'd7,     16'd0,  16'd0,  16'd9,      16'd7,     1'b0};
      vecs[5] = '{16'd0,     16'd1,  16'd0,  16'd100,    16'd100,   1'b0};
      vecs[6] = '{16'hFFFF,  16'd1,  16'd0,  16'd1,      16'd0,     1'b1};
      vecs[7] = '{16'd10,    16'd20, 16'd30, 16'd3,      16'd340,   1'b0};

      bus2.coef_we = 1'b0; bus2.coef_addr = '0; bus2.coef_data = '0; bus2.start = 1'b0; bus2.x = '0;
      bus0.coef_we = 1'b0; bus0.coef_addr = '0; bus0.coef_data = '0; bus0.start = 1'b0; bus0.x = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset busy", 32'(bus2.busy), 32'd0);
      check("reset done", 32'(bus2.done), 32'd0);
      check("reset resultado", 32'(bus2.resultado), 32'd0);
      check("reset ovf", 32'(bus2.ovf), 32'd0);

      for (int v = 0; v < 8; v++) begin
         load3(vecs[v].c0, vecs[v].c1, vecs[v].c2);
         eval2(vecs[v].xv, lat);
         $display("vec %0d: x=%h resultado=%h ovf=%b latency=%0d", v, vecs[v].xv,
                  bus2.resultado, bus2.ovf, lat);
         check($sformatf("vec%0d latency", v), 32'(lat), 32'd6);
         check($sformatf("vec%0d resultado", v), 32'(bus2.resultado), 32'(vecs[v].res));
         check($sformatf("vec%0d ovf", v), 32'(bus2.ovf), 32'(vecs[v].ovf & OVF_ON));
         tick();
         check($sformatf("vec%0d done pulse", v), 32'(bus2.done), 32'd0);
         check($sformatf("vec%0d idle", v), 32'(bus2.busy), 32'd0);
         check($sformatf("vec%0d hold", v), 32'(bus2.resultado), 32'(vecs[v].res));
      end

      // Second start while busy, plus x changing mid-run.
      load3(16'd3, 16'd2, 16'd1);
      bus2.start = 1'b1; bus2.x = 16'd5;
      tick();
      bus2.start = 1'b0;
      tick();
      check("busy hold resultado", 32'(bus2.resultado), 32'd340);
      bus2.start = 1'b1; bus2.x = 16'd7;
      tick();
      bus2.start = 1'b0; bus2.x = 16'd9;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus2.done) ndone++;
         tick();
      end
      $display("restart-while-busy: dones=%0d resultado=%h", ndone, bus2.resultado);
      check("ignored start dones", 32'(ndone), 32'd1);
      check("ignored start resultado", 32'(bus2.resultado), 32'd38);

      // Reset in MUL state.
      bus2.start = 1'b1; bus2.x = 16'd5;
      tick();
      bus2.start = 1'b0;
      tick();
      check("in MUL busy", 32'(bus2.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      $display("reset-in-MUL: busy=%b done=%b resultado=%h", bus2.busy, bus2.done, bus2.resultado);
      check("mid rst busy", 32'(bus2.busy), 32'd0);
      check("mid rst done", 32'(bus2.done), 32'd0);
      check("mid rst resultado", 32'(bus2.resultado), 32'd0);
      eval2(16'd5, lat);
      check("coefs cleared", 32'(bus2.resultado), 32'd0);
      tick();
      load3(16'd3, 16'd2, 16'd1);
      eval2(16'd5, lat);
      $display("after reset reload: resultado=%h latency=%0d", bus2.resultado, lat);
      check("post rst resultado", 32'(bus2.resultado), 32'd38);
      tick();

      // rst and start together.
      rst = 1'b1; bus2.start = 1'b1; bus2.x = 16'd5;
      tick();
      rst = 1'b0; bus2.start = 1'b0;
      tick();
      check("rst beats start", 32'(bus2.busy), 32'd0);

      // Out-of-range write and write while busy.
      load3(16'd3, 16'd2, 16'd1);
      wr2(2'd3, 16'h00FF);
      bus2.start = 1'b1; bus2.x = 16'd5;
      tick();
      bus2.start = 1'b0;
      wr2(2'd0, 16'hFFFF);
      lat = 2;
      while (!bus2.done && lat < 50) begin
         tick();
         lat++;
      end
      check("busy write ignored", 32'(bus2.resultado), 32'd38);
      tick();
      eval2(16'd5, lat);
      $display("ignored writes: resultado=%h", bus2.resultado);
      check("coef0 intact", 32'(bus2.resultado), 32'd38);
      tick();

      // DEGREE=0 instance.
      bus0.coef_we = 1'b1; bus0.coef_addr = 1'b0; bus0.coef_data = 16'h1234;
      tick();
      bus0.coef_we = 1'b0;
      bus0.start = 1'b1; bus0.x = 16'hABCD;
      tick();
      bus0.start = 1'b0;
      lat = 1;
      while (!bus0.done && lat < 50) begin
         tick();
         lat++;
      end
      $display("degree0: resultado=%h latency=%0d", bus0.resultado, lat);
      check("deg0 latency", 32'(lat), 32'd2);
      check("deg0 resultado", 32'(bus0.resultado), 32'h1234);
      check("deg0 ovf", 32'(bus0.ovf), 32'd0);
      tick();
      check("deg0 done pulse", 32'(bus0.done), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
